// File: rtl/bit_stuff_up.sv
// Upstream bit stuffer and NRZI line encoder: takes one packet bit per bit-time strobe,
// inserts a 0 after STUFF_LEN consecutive 1s, drives dp/dm and appends SE0,SE0,J.
module bit_stuff_up #(
    parameter int STUFF_LEN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  logic in_data,
    input  logic in_last,
    output logic in_ready,
    output logic dp,
    output logic dm,
    output logic tx_active,
    output logic stuffed,
    output logic underrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_STUFF = 3'd2;
    localparam logic [2:0] S_EOP1  = 3'd3;
    localparam logic [2:0] S_EOP2  = 3'd4;
    localparam logic [2:0] S_EOPJ  = 3'd5;

    localparam logic [3:0] STUFF_CNT = 4'(STUFF_LEN);

    logic [2:0] state, state_n;
    logic [3:0] ones_cnt, ones_n;
    logic       level, level_n;   // NRZI level, 1 = J
    logic       pend_stuff, pend_stuff_n;
    logic       pend_eop, pend_eop_n;
    logic       dp_n, dm_n, tx_n, stuffed_n, underrun_n;
    logic       accept;

    // STUFF behaves as DATA on its strobe, so the bit following a stuff bit is taken there.
    assign in_ready = en & (state == S_IDLE || state == S_DATA || state == S_STUFF)
                      & ~pend_stuff & ~pend_eop;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_n      = state;
        ones_n       = ones_cnt;
        level_n      = level;
        pend_stuff_n = pend_stuff;
        pend_eop_n   = pend_eop;
        dp_n         = dp;
        dm_n         = dm;
        tx_n         = tx_active;
        stuffed_n    = stuffed;
        underrun_n   = 1'b0;
        accept       = 1'b0;

        if (en) begin
            stuffed_n = 1'b0;
            case (state)
                S_IDLE: accept = in_valid;
                S_DATA, S_STUFF: begin
                    if (pend_stuff) begin
                        level_n      = ~level;
                        dp_n         = ~level;
                        dm_n         = level;
                        stuffed_n    = 1'b1;
                        ones_n       = 4'd0;
                        pend_stuff_n = 1'b0;
                        state_n      = S_STUFF;
                    end else if (pend_eop) begin
                        pend_eop_n = 1'b0;
                        dp_n       = 1'b0;
                        dm_n       = 1'b0;
                        state_n    = S_EOP1;
                    end else if (in_valid) begin
                        accept = 1'b1;
                    end else begin
                        underrun_n = 1'b1;
                        dp_n       = 1'b0;
                        dm_n       = 1'b0;
                        state_n    = S_EOP1;
                    end
                end
                S_EOP1: state_n = S_EOP2;
                S_EOP2: begin
                    dp_n    = 1'b1;
                    dm_n    = 1'b0;
                    state_n = S_EOPJ;
                end
                S_EOPJ: begin
                    tx_n         = 1'b0;
                    ones_n       = 4'd0;
                    level_n      = 1'b1;
                    pend_stuff_n = 1'b0;
                    pend_eop_n   = 1'b0;
                    state_n      = S_IDLE;
                end
                default: begin
                    dp_n    = 1'b1;
                    dm_n    = 1'b0;
                    tx_n    = 1'b0;
                    level_n = 1'b1;
                    state_n = S_IDLE;
                end
            endcase

            if (accept) begin
                level_n    = in_data ? level : ~level;
                dp_n       = level_n;
                dm_n       = ~level_n;
                tx_n       = 1'b1;
                pend_eop_n = in_last;
                state_n    = S_DATA;
                if (in_data) begin
                    ones_n = ones_cnt + 4'd1;
                    if (ones_n == STUFF_CNT) pend_stuff_n = 1'b1;
                end else begin
                    ones_n = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            state      <= S_IDLE;
            ones_cnt   <= 4'd0;
            level      <= 1'b1;
            pend_stuff <= 1'b0;
            pend_eop   <= 1'b0;
            dp         <= 1'b1;
            dm         <= 1'b0;
            tx_active  <= 1'b0;
            stuffed    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            ones_cnt   <= ones_n;
            level      <= level_n;
            pend_stuff <= pend_stuff_n;
            pend_eop   <= pend_eop_n;
            dp         <= dp_n;
            dm         <= dm_n;
            tx_active  <= tx_n;
            stuffed    <= stuffed_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: tb/tb_bit_stuff_up.sv
// Directed bench for bit_stuff_up: each bit time is driven with hand-computed expected
// line state ({dp,dm}: J=10, K=01, SE0=00), in_ready, tx_active, stuffed and underrun.
module tb_bit_stuff_up;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst, en, in_valid, in_data, in_last;
    logic in_ready, dp, dm, tx_active, stuffed, underrun;

    int n_tests = 0;
    int n_fail  = 0;

    bit_stuff_up #(.STUFF_LEN(6)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .dp(dp), .dm(dm), .tx_active(tx_active),
        .stuffed(stuffed), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with en=1; inputs are driven one time unit after the previous edge.
    task automatic strobe(input string tag, input logic v, input logic d, input logic l,
                          input logic e_rdy, input logic [1:0] e_line,
                          input logic e_tx, input logic e_stf, input logic e_und);
        en = 1'b1; in_valid = v; in_data = d; in_last = l;
        #1 check({tag, ".ready"}, {1'b0, in_ready}, {1'b0, e_rdy});
        @(posedge clk); #1;
        check({tag, ".line"}, {dp, dm}, e_line);
        check({tag, ".tx"}, {1'b0, tx_active}, {1'b0, e_tx});
        check({tag, ".stuffed"}, {1'b0, stuffed}, {1'b0, e_stf});
        check({tag, ".underrun"}, {1'b0, underrun}, {1'b0, e_und});
    endtask

    // One clock with en=0; nothing may move.
    task automatic hold(input string tag, input logic [1:0] e_line, input logic e_tx,
                        input logic e_stf);
        en = 1'b0;
        #1 check({tag, ".ready"}, {1'b0, in_ready}, 2'b00);
        @(posedge clk); #1;
        check({tag, ".line"}, {dp, dm}, e_line);
        check({tag, ".tx"}, {1'b0, tx_active}, {1'b0, e_tx});
        check({tag, ".stuffed"}, {1'b0, stuffed}, {1'b0, e_stf});
    endtask

    // Finish from the state where EOP1 is next: SE0, SE0, J, then IDLE.
    task automatic eop_tail(input string tag);
        strobe({tag, ".eop1"}, 1'b0, 1'b0, 1'b0, 1'b0, SE0, 1'b1, 1'b0, 1'b0);
        strobe({tag, ".eop2"}, 1'b0, 1'b0, 1'b0, 1'b0, J,   1'b1, 1'b0, 1'b0);
        strobe({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, J,   1'b0, 1'b0, 1'b0);
        strobe({tag, ".rdy"},  1'b0, 1'b0, 1'b0, 1'b1, J,   1'b0, 1'b0, 1'b0);
    endtask

    logic [1:0] t1_line [8] = '{K, J, K, J, K, J, K, K};

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst.line", {dp, dm}, J);
        check("rst.tx", {1'b0, tx_active}, 2'b00);
        check("rst.stuffed", {1'b0, stuffed}, 2'b00);
        check("rst.underrun", {1'b0, underrun}, 2'b00);
        check("rst.ready", {1'b0, in_ready}, 2'b00);
        rst = 1'b0;

        // 1: seven 0s then a 1 (last)
        for (int i = 0; i < 8; i++)
            strobe($sformatf("t1.b%0d", i), 1'b1, (i == 7), (i == 7), 1'b1, t1_line[i],
                   1'b1, 1'b0, 1'b0);
        strobe("t1.se0a", 1'b0, 1'b0, 1'b0, 1'b0, SE0, 1'b1, 1'b0, 1'b0);
        eop_tail("t1");

        // 2: seven 1s then 0 (last); stuff after the sixth
        for (int i = 0; i < 6; i++)
            strobe($sformatf("t2.b%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t2.stuff", 1'b1, 1'b1, 1'b0, 1'b0, K, 1'b1, 1'b1, 1'b0);
        strobe("t2.b6",    1'b1, 1'b1, 1'b0, 1'b1, K, 1'b1, 1'b0, 1'b0);
        strobe("t2.b7",    1'b1, 1'b0, 1'b1, 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t2.se0a",  1'b0, 1'b0, 1'b0, 1'b0, SE0, 1'b1, 1'b0, 1'b0);
        eop_tail("t2");

        // 3: exactly six 1s, last on the sixth; stuffing precedes EOP
        for (int i = 0; i < 6; i++)
            strobe($sformatf("t3.b%0d", i), 1'b1, 1'b1, (i == 5), 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t3.stuff", 1'b0, 1'b0, 1'b0, 1'b0, K,   1'b1, 1'b1, 1'b0);
        strobe("t3.se0a",  1'b0, 1'b0, 1'b0, 1'b0, SE0, 1'b1, 1'b0, 1'b0);
        eop_tail("t3");

        // 4: underrun after three bits (1,0,1)
        strobe("t4.b0", 1'b1, 1'b1, 1'b0, 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t4.b1", 1'b1, 1'b0, 1'b0, 1'b1, K, 1'b1, 1'b0, 1'b0);
        strobe("t4.b2", 1'b1, 1'b1, 1'b0, 1'b1, K, 1'b1, 1'b0, 1'b0);
        strobe("t4.und", 1'b0, 1'b0, 1'b0, 1'b1, SE0, 1'b1, 1'b0, 1'b1);
        eop_tail("t4");

        // 5: strobe every 4th cycle; bits 0,1,0(last)
        strobe("t5.b0", 1'b1, 1'b0, 1'b0, 1'b1, K, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold($sformatf("t5.h0_%0d", i), K, 1'b1, 1'b0);
        strobe("t5.b1", 1'b1, 1'b1, 1'b0, 1'b1, K, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold($sformatf("t5.h1_%0d", i), K, 1'b1, 1'b0);
        strobe("t5.b2", 1'b1, 1'b0, 1'b1, 1'b1, J, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold($sformatf("t5.h2_%0d", i), J, 1'b1, 1'b0);
        strobe("t5.se0a", 1'b1, 1'b0, 1'b0, 1'b0, SE0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold($sformatf("t5.h3_%0d", i), SE0, 1'b1, 1'b0);
        eop_tail("t5");

        // 6: reset while in STUFF, then a fresh packet of six 1s
        for (int i = 0; i < 6; i++)
            strobe($sformatf("t6.b%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t6.stuff", 1'b0, 1'b0, 1'b0, 1'b0, K, 1'b1, 1'b1, 1'b0);
        rst = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6.rst.line", {dp, dm}, J);
        check("t6.rst.tx", {1'b0, tx_active}, 2'b00);
        check("t6.rst.stuffed", {1'b0, stuffed}, 2'b00);
        for (int i = 0; i < 6; i++)
            strobe($sformatf("t6.n%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t6.stuff2", 1'b1, 1'b0, 1'b1, 1'b0, K, 1'b1, 1'b1, 1'b0);
        strobe("t6.last",   1'b1, 1'b0, 1'b1, 1'b1, J, 1'b1, 1'b0, 1'b0);
        strobe("t6.se0a",   1'b0, 1'b0, 1'b0, 1'b0, SE0, 1'b1, 1'b0, 1'b0);
        eop_tail("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
